// File: rtl/instruction_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instruction_sequencer: four-phase ADD/SUB/LI/DISP sequencer that drives an  |
// | external register file and retires one instruction every four cycles.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module instruction_sequencer #(
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   input_Clock,
  input  logic                   input_Reset,
  input  logic                   input_Instruction_Valid,
  input  logic [7:0]             input_Instruction,
  output logic                   output_Instruction_Ready,
  input  logic [7:0]             input_Read_Data1,
  input  logic [7:0]             input_Read_Data2,
  output logic                   output_Read_Write,
  output logic [1:0]             output_Read_Register1,
  output logic [1:0]             output_Read_Register2,
  output logic [1:0]             output_Write_Register,
  output logic [7:0]             output_Write_Data,
  output logic                   output_Display_Valid,
  output logic [7:0]             output_Display_Data,
  output logic [COUNT_WIDTH-1:0] output_Instruction_Count
);

  localparam logic [1:0] c_OP_ADD  = 2'b00;
  localparam logic [1:0] c_OP_LI   = 2'b01;
  localparam logic [1:0] c_OP_DISP = 2'b10;
  localparam logic [1:0] c_OP_SUB  = 2'b11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DECODE    = 2'd1,
    EXECUTE   = 2'd2,
    WRITEBACK = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [7:0]             r_instr;
  logic [7:0]             r_result;
  logic [7:0]             r_display_data;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   w_accept;
  logic                   w_writes_reg;
  logic [1:0]             w_op;
  logic [1:0]             w_rs;
  logic [1:0]             w_rt;
  logic [1:0]             w_rd;
  logic [7:0]             w_result;

  assign w_op = r_instr[7:6];
  assign w_rs = r_instr[5:4];
  assign w_rt = r_instr[3:2];
  assign w_rd = r_instr[1:0];
  assign w_writes_reg = (w_op != c_OP_DISP);

  always_comb begin
    w_result = input_Read_Data1;
    case (w_op)
      c_OP_ADD: w_result = input_Read_Data1 + input_Read_Data2;
      c_OP_SUB: w_result = input_Read_Data1 - input_Read_Data2;
      c_OP_LI:  w_result = {{4{r_instr[3]}}, r_instr[3:0]};
      default:  w_result = input_Read_Data1;
    endcase
  end

  always_ff @(posedge input_Clock or posedge input_Reset) begin
    if (input_Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next             = r_state;
    w_accept                 = 1'b0;
    output_Instruction_Ready = 1'b0;
    output_Read_Register1    = 2'b00;
    output_Read_Register2    = 2'b00;
    output_Read_Write        = 1'b0;
    output_Write_Register    = 2'b00;
    output_Write_Data        = 8'h00;
    output_Display_Valid     = 1'b0;
    case (r_state)
      IDLE: begin
        // Ready is suppressed while reset is held so no transfer can occur.
        output_Instruction_Ready = ~input_Reset;
        w_accept                 = input_Instruction_Valid & ~input_Reset;
        if (w_accept) w_state_next = DECODE;
      end
      DECODE: begin
        output_Read_Register1 = w_rs;
        output_Read_Register2 = w_rt;
        w_state_next          = EXECUTE;
      end
      EXECUTE: begin
        output_Read_Register1 = w_rs;
        output_Read_Register2 = w_rt;
        w_state_next          = WRITEBACK;
      end
      WRITEBACK: begin
        // LI writes the register named in the rs field; ADD/SUB write rd.
        output_Read_Write     = w_writes_reg;
        output_Write_Register = !w_writes_reg ? 2'b00 : (w_op == c_OP_LI) ? w_rs : w_rd;
        output_Write_Data     = w_writes_reg ? r_result : 8'h00;
        output_Display_Valid  = ~w_writes_reg;
        w_state_next          = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge input_Clock or posedge input_Reset) begin
    if (input_Reset) begin
      r_instr        <= 8'h00;
      r_result       <= 8'h00;
      r_display_data <= 8'h00;
      r_count        <= '0;
    end else begin
      if (w_accept) r_instr <= input_Instruction;
      // Operands are captured before any write, so aliased rs/rt/rd are safe.
      if (r_state == EXECUTE) begin
        r_result <= w_result;
        if (!w_writes_reg) r_display_data <= input_Read_Data1;
      end
      if (r_state == WRITEBACK) r_count <= r_count + COUNT_WIDTH'(1);
    end
  end

  assign output_Display_Data      = r_display_data;
  assign output_Instruction_Count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instruction_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_instruction_sequencer: randomized bench for instruction_sequencer with   |
// | an external register file and an instruction-level reference model.        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_instruction_sequencer;

  localparam int CW = 2;

  logic          clk;
  logic          rst;
  logic          valid;
  logic [7:0]    instr;
  logic          ready;
  logic [7:0]    rd1;
  logic [7:0]    rd2;
  logic          rw;
  logic [1:0]    rr1;
  logic [1:0]    rr2;
  logic [1:0]    wreg;
  logic [7:0]    wdata;
  logic          dvalid;
  logic [7:0]    ddata;
  logic [CW-1:0] count;

  logic [7:0]    rf [4];
  logic          poke;
  logic [1:0]    poke_idx;
  logic [7:0]    poke_val;

  logic [7:0]    mregs [4];
  logic [7:0]    exp_disp;
  logic [CW-1:0] exp_count;
  int            n_tests;
  int            n_fail;

  instruction_sequencer #(.COUNT_WIDTH(CW)) dut (
    .input_Clock              (clk),
    .input_Reset              (rst),
    .input_Instruction_Valid  (valid),
    .input_Instruction        (instr),
    .output_Instruction_Ready (ready),
    .input_Read_Data1         (rd1),
    .input_Read_Data2         (rd2),
    .output_Read_Write        (rw),
    .output_Read_Register1    (rr1),
    .output_Read_Register2    (rr2),
    .output_Write_Register    (wreg),
    .output_Write_Data        (wdata),
    .output_Display_Valid     (dvalid),
    .output_Display_Data      (ddata),
    .output_Instruction_Count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file the sequencer talks to; pokes let the bench preload values.
  assign rd1 = rf[rr1];
  assign rd2 = rf[rr2];
  always @(posedge clk) begin
    if (poke) rf[poke_idx] <= poke_val;
    else if (rw) rf[wreg] <= wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [1:0] idx, input logic [7:0] val);
    poke = 1'b1; poke_idx = idx; poke_val = val;
    tick();
    poke = 1'b0;
    mregs[idx] = val;
  endtask

  // Sends one instruction from IDLE and checks every phase against the model.
  task automatic run_instr(input logic [7:0] w, input bit busy);
    logic [1:0] op, rs, rt, rd, dst;
    logic [7:0] a, b, res;
    bit         wr_en;
    op = w[7:6]; rs = w[5:4]; rt = w[3:2]; rd = w[1:0];
    a = mregs[rs]; b = mregs[rt];
    case (op)
      2'b00:   res = 8'((int'(a) + int'(b)) % 256);
      2'b11:   res = 8'((int'(a) - int'(b) + 256) % 256);
      2'b01:   res = (w[3] ? 8'hF0 : 8'h00) | {4'h0, w[3:0]};
      default: res = a;
    endcase
    wr_en = (op != 2'b10);
    dst   = (op == 2'b01) ? rs : rd;

    chk("idle_ready", ready, 1);
    valid = 1'b1; instr = w;
    tick();
    if (busy) instr = 8'($urandom);
    else valid = 1'b0;
    chk("dec_ready", ready, 0);
    chk("dec_rr1", rr1, rs);
    chk("dec_rr2", rr2, rt);
    chk("dec_rw", rw, 0);
    tick();
    chk("exe_rr1", rr1, rs);
    chk("exe_rr2", rr2, rt);
    chk("exe_rw", rw, 0);
    chk("exe_dvalid", dvalid, 0);
    tick();
    if (!wr_en) exp_disp = res;
    chk("wb_ready", ready, 0);
    chk("wb_rw", rw, wr_en);
    chk("wb_wreg", wreg, wr_en ? dst : 2'b00);
    chk("wb_wdata", wdata, wr_en ? res : 8'h00);
    chk("wb_dvalid", dvalid, !wr_en);
    chk("wb_ddata", ddata, exp_disp);
    chk("wb_count", count, exp_count);
    tick();
    valid = 1'b0;
    exp_count = exp_count + 1'b1;
    if (wr_en) mregs[dst] = res;
    chk("idle_ready_back", ready, 1);
    chk("idle_rw", rw, 0);
    chk("idle_wreg", wreg, 0);
    chk("idle_dvalid", dvalid, 0);
    chk("idle_count", count, exp_count);
    chk("idle_ddata", ddata, exp_disp);
    if (busy) begin
      tick();
      chk("busy_word_dropped", ready, 1);
      chk("busy_count", count, exp_count);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; valid = 1'b0; instr = 8'h00;
    poke = 1'b0; poke_idx = 2'b00; poke_val = 8'h00;
    exp_disp = 8'h00; exp_count = '0;
    for (int i = 0; i < 4; i++) mregs[i] = 8'h00;

    tick();
    valid = 1'b1; instr = 8'h55;
    tick();
    chk("rst_ready", ready, 0);
    chk("rst_rw", rw, 0);
    chk("rst_rr1", rr1, 0);
    chk("rst_count", count, 0);
    chk("rst_ddata", ddata, 0);
    valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rel_ready", ready, 1);

    for (int i = 0; i < 4; i++) preload(2'(i), 8'($urandom));

    run_instr(8'h55, 1'b0);  // LI R1,5
    run_instr(8'h6F, 1'b0);  // LI R2,-1
    run_instr(8'h19, 1'b0);  // ADD R1 = R1 + R2 with carry out discarded
    preload(2'd1, 8'h35);
    run_instr(8'h90, 1'b0);  // DISP R1, count wraps to 0
    run_instr(8'($urandom), 1'b1);

    for (int i = 0; i < 40; i++) run_instr(8'($urandom), 1'($urandom_range(0, 1)));

    for (int i = 0; i < 4 && exp_count != '0; i++) run_instr(8'($urandom), 1'b0);
    chk("pre_abort_count", count, exp_count);

    // Abort a register-writing instruction in EXECUTE.
    valid = 1'b1; instr = {2'b01, 6'($urandom)};
    tick();
    valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    exp_disp = 8'h00;
    chk("abort_ready", ready, 0);
    chk("abort_rw", rw, 0);
    chk("abort_rr1", rr1, 0);
    chk("abort_rr2", rr2, 0);
    chk("abort_count", count, 0);
    chk("abort_ddata", ddata, 0);
    tick();
    chk("abort_hold_rw", rw, 0);
    chk("abort_hold_ready", ready, 0);
    rst = 1'b0;
    #1;
    chk("abort_rel_ready", ready, 1);
    tick();
    chk("abort_no_wb", rw, 0);
    chk("abort_no_count", count, 0);
    exp_count = '0;

    run_instr(8'($urandom), 1'b0);
    run_instr(8'h90, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
